// File: rtl/debounce_sync.sv
// Input conditioner: two-flop synchronizer, then a qualification counter. The clean
// level x follows the pin only after STABLE_CYCLES consecutive disagreeing samples.
module debounce_sync #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       x,
    output logic       rise,
    output logic       fall,
    output logic [7:0] evt_cnt
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             x_q, x_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       evt_cnt_q, evt_cnt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s1_d      = btn_in;
        s2_d      = s1_q;
        x_d       = x_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        evt_cnt_d = evt_cnt_q;

        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (s2_q != x_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_COUNTING: begin
                // A bounce back to x wins even on the cycle the limit is reached.
                if (s2_q == x_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    x_d     = s2_q;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                    if (s2_q) begin
                        evt_cnt_d = evt_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            x_q       <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            evt_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            x_q       <= x_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign x       = x_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed scenarios plus random bouncing, checked cycle by
// cycle against a sliding-window model of the debounce rule.
module tb_debounce_sync;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic       btn_in;
    logic       x;
    logic       rise;
    logic       fall;
    logic [7:0] evt_cnt;

    debounce_sync #(
        .STABLE_CYCLES(N),
        .CNT_W        (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_in (btn_in),
        .x      (x),
        .rise   (rise),
        .fall   (fall),
        .evt_cnt(evt_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // expected word: {x, rise, fall, evt_cnt}
    logic [10:0] exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int rise_seen   = 0;
    int rise_model  = 0;
    bit done        = 1'b0;

    // reference model: pipeline of pin samples and a window of the last N s2 samples
    bit m_s1, m_s2, m_x;
    bit win[$];
    int m_evt;

    task automatic model_step(input bit rst_in, input bit btn);
        bit acc;
        bit r;
        bit f;
        acc = 1'b0;
        r   = 1'b0;
        f   = 1'b0;
        if (!rst_in) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_x   = 1'b0;
            m_evt = 0;
            win.delete();
        end else begin
            win.push_back(m_s2);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                acc = 1'b1;
                foreach (win[i]) if (win[i] == m_x) acc = 1'b0;
            end
            if (acc) begin
                m_x = ~m_x;
                r   = m_x;
                f   = ~m_x;
                if (r) begin
                    m_evt      = (m_evt + 1) % 256;
                    rise_model = rise_model + 1;
                end
                win.delete();
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
        exp_q.push_back({m_x, r, f, 8'(m_evt)});
    endtask

    // driver: inputs change on the falling edge, expectation queued for the next rise
    task automatic drive(input bit rst_in, input bit btn, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n  = rst_in;
            btn_in = btn;
            model_step(rst_in, btn);
        end
    endtask

    task automatic press(input int hi, input int lo);
        drive(1'b1, 1'b1, hi);
        drive(1'b1, 1'b0, lo);
    endtask

    // monitor / scoreboard
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rise === 1'b1) rise_seen = rise_seen + 1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors = vectors + 1;
                if (x !== e[10]) begin
                    miscompares = miscompares + 1;
                    $display("FAIL x at %0t: got %b want %b", $time, x, e[10]);
                end
                if (rise !== e[9]) begin
                    miscompares = miscompares + 1;
                    $display("FAIL rise at %0t: got %b want %b", $time, rise, e[9]);
                end
                if (fall !== e[8]) begin
                    miscompares = miscompares + 1;
                    $display("FAIL fall at %0t: got %b want %b", $time, fall, e[8]);
                end
                if (evt_cnt !== e[7:0]) begin
                    miscompares = miscompares + 1;
                    $display("FAIL evt_cnt at %0t: got %0d want %0d", $time, evt_cnt, e[7:0]);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        btn_in = 1'b0;
        drive(1'b0, 1'b0, 3);

        // clean press and release
        press(12, 12);
        // bounce: high 3, low 1, then steady high
        drive(1'b1, 1'b1, 3);
        drive(1'b1, 1'b0, 1);
        press(12, 12);
        // reset on edge 4 of a qualifying press, pin still high afterwards
        drive(1'b1, 1'b1, 3);
        drive(1'b0, 1'b1, 1);
        press(12, 12);
        // reset released with the pin already high
        drive(1'b0, 1'b1, 2);
        press(12, 12);
        // threshold glitches: 3-cycle pulse ignored, 4-cycle pulse accepted
        press(N - 1, 12);
        press(N, 12);
        // evt_cnt wrap: start from a clean count, then 256 presses
        drive(1'b0, 1'b0, 2);
        for (int p = 0; p < 256; p++) press(N + 2, N + 2);

        // random bouncing with occasional resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 49) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            else
                drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, N + 3));
        end
        drive(1'b1, 1'b0, 12);

        @(posedge clk);
        #2;
        done = 1'b1;
        vectors = vectors + 1;
        if (rise_seen != rise_model) begin
            miscompares = miscompares + 1;
            $display("FAIL rise_total: got %0d want %0d", rise_seen, rise_model);
        end
        vectors = vectors + 1;
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
